// File: rtl/proctypes.sv
// rtl/proctypes.sv - processor-wide constants and the frame buffer state type
package proctypes;

  localparam int NUM_INSTRUCTIONS       = 16;
  localparam int NUM_INSTRUCTIONS_WIDTH = $clog2(NUM_INSTRUCTIONS);
  localparam int INSTR_W                = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } FrameState;

endpackage

// File: rtl/instr_ring_ram.sv
// rtl/instr_ring_ram.sv - simple dual-port ring storage with registered read port
module instr_ring_ram #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read register only updates on re, so it doubles as the held output stage.
  always_ff @(posedge clk) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/instr_frame_buffer.sv
// rtl/instr_frame_buffer.sv - frame-committing instruction buffer between checksum and parser
module instr_frame_buffer
  import proctypes::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              axiiv,
  input  logic [31:0]                       axiid,
  input  logic                              frame_done,
  input  logic                              frame_kill,
  output logic                              axiov,
  output logic [31:0]                       axiod,
  input  logic                              axior,
  output logic [NUM_INSTRUCTIONS_WIDTH-1:0] pc,
  output logic                              overflow,
  output logic [7:0]                        frames_dropped
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  FrameState state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, cm_ptr_q, cm_ptr_d, rd_ptr_q, rd_ptr_d;
  logic          frame_done_q, frame_done_d;
  logic          axiov_q, axiov_d;
  logic [NUM_INSTRUCTIONS_WIDTH-1:0] pc_q, pc_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    dropped_q, dropped_d;

  logic done_edge, full, wr_en, rollback, rd_en, xfer;

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    cm_ptr_d     = cm_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    frame_done_d = frame_done;
    overflow_d   = overflow_q;
    dropped_d    = dropped_q;
    pc_d         = pc_q;
    wr_en        = 1'b0;
    rollback     = 1'b0;
    done_edge    = frame_done & ~frame_done_q;
    full         = (wr_ptr_q - rd_ptr_q) == PW'(DEPTH);

    unique case (state_q)
      IDLE: begin
        if (axiiv) begin
          if (full) begin
            overflow_d = 1'b1;
            state_d    = DROP;
          end else begin
            wr_en   = 1'b1;
            state_d = RECV;
          end
        end
      end
      RECV: begin
        if (frame_kill) begin
          rollback = 1'b1;
        end else if (axiiv && full) begin
          overflow_d = 1'b1;
          if (done_edge) rollback = 1'b1;
          else           state_d  = DROP;
        end else begin
          wr_en = axiiv;
          // Commit includes a word written in this same cycle.
          if (done_edge) begin
            cm_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
            state_d  = IDLE;
          end
        end
      end
      DROP: begin
        if (frame_kill || done_edge) rollback = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rollback) begin
      wr_ptr_d = cm_ptr_q;
      state_d  = IDLE;
      if (dropped_q != 8'hff) dropped_d = dropped_q + 8'd1;
    end

    xfer    = axiov_q & axior;
    rd_en   = (rd_ptr_q != cm_ptr_q) && (!axiov_q || axior);
    axiov_d = rd_en | (axiov_q & ~axior);
    if (rd_en) rd_ptr_d = rd_ptr_q + 1'b1;
    if (xfer) begin
      if (pc_q == NUM_INSTRUCTIONS_WIDTH'(NUM_INSTRUCTIONS - 1)) pc_d = '0;
      else                                                      pc_d = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      cm_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      frame_done_q <= 1'b0;
      axiov_q      <= 1'b0;
      pc_q         <= '0;
      overflow_q   <= 1'b0;
      dropped_q    <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      cm_ptr_q     <= cm_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      frame_done_q <= frame_done_d;
      axiov_q      <= axiov_d;
      pc_q         <= pc_d;
      overflow_q   <= overflow_d;
      dropped_q    <= dropped_d;
    end
  end

  instr_ring_ram #(.DEPTH(DEPTH), .WIDTH(INSTR_W)) u_ring (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (axiid),
    .re    (rd_en),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (axiod)
  );

  assign axiov          = axiov_q;
  assign pc             = pc_q;
  assign overflow       = overflow_q;
  assign frames_dropped = dropped_q;

endmodule

// File: tb/tb_instr_frame_buffer.sv
// tb/tb_instr_frame_buffer.sv - randomized and directed bench with queue-based reference model
module tb_instr_frame_buffer;

  localparam int DEPTH = 4;
  localparam int NI    = proctypes::NUM_INSTRUCTIONS;
  localparam int NW    = proctypes::NUM_INSTRUCTIONS_WIDTH;

  logic          clk = 1'b0;
  logic          rst, axiiv, frame_done, frame_kill, axior;
  logic [31:0]   axiid;
  logic          axiov, overflow;
  logic [31:0]   axiod;
  logic [NW-1:0] pc;
  logic [7:0]    frames_dropped;

  int checks = 0;
  int errors = 0;

  // Model: pending frame words, committed-but-unloaded words, one output slot.
  int          m_state;
  logic [31:0] pq[$];
  logic [31:0] cq[$];
  bit          sv;
  logic [31:0] sw;
  int          mpc, mdrop;
  bit          movf, mfd_prev;

  instr_frame_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
    .frame_done(frame_done), .frame_kill(frame_kill),
    .axiov(axiov), .axiod(axiod), .axior(axior), .pc(pc),
    .overflow(overflow), .frames_dropped(frames_dropped)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drop_frame();
    pq.delete();
    m_state = 0;
    if (mdrop < 255) mdrop++;
  endtask

  task automatic model_step();
    bit          xfer, load, full, de;
    logic [31:0] popped;
    if (rst) begin
      m_state = 0; pq.delete(); cq.delete();
      sv = 0; sw = '0; mpc = 0; mdrop = 0; movf = 0; mfd_prev = 0;
      return;
    end
    xfer   = sv && axior;
    load   = (cq.size() > 0) && (!sv || axior);
    full   = (pq.size() + cq.size()) == DEPTH;
    de     = frame_done && !mfd_prev;
    popped = '0;
    if (load) popped = cq.pop_front();
    case (m_state)
      0: if (axiiv) begin
           if (full) begin movf = 1; m_state = 2; end
           else begin pq.push_back(axiid); m_state = 1; end
         end
      1: if (frame_kill) drop_frame();
         else if (axiiv && full) begin
           movf = 1;
           if (de) drop_frame(); else m_state = 2;
         end else begin
           if (axiiv) pq.push_back(axiid);
           if (de) begin
             foreach (pq[i]) cq.push_back(pq[i]);
             pq.delete();
             m_state = 0;
           end
         end
      default: if (frame_kill || de) drop_frame();
    endcase
    if (load) begin sv = 1; sw = popped; end
    else if (xfer) sv = 0;
    if (xfer) mpc = (mpc + 1) % NI;
    mfd_prev = frame_done;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_val("axiov", {31'd0, axiov}, {31'd0, sv});
    check_val("axiod", axiod, sw);
    check_val("pc", 32'(pc), 32'(mpc));
    check_val("overflow", {31'd0, overflow}, {31'd0, movf});
    check_val("frames_dropped", {24'd0, frames_dropped}, 32'(mdrop));
  endtask

  task automatic do_reset();
    rst = 1; axiiv = 0; frame_done = 0; frame_kill = 0;
    tick();
    rst = 0;
  endtask

  task automatic send_word(input logic [31:0] w);
    axiiv = 1; axiid = w;
    tick();
    axiiv = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1; axiiv = 0; axiid = '0; frame_done = 0; frame_kill = 0; axior = 0;
    @(negedge clk);
    tick(); tick();
    check_val("reset_axiov", {31'd0, axiov}, 32'd0);
    check_val("reset_pc", 32'(pc), 32'd0);
    rst = 0;

    // Good 3-word frame, latency and ordering.
    axior = 1;
    for (int i = 1; i <= 3; i++) send_word(32'hA000_0000 + 32'(i));
    frame_done = 1;
    tick();
    check_val("latency_cycle1", {31'd0, axiov}, 32'd0);
    tick();
    check_val("latency_cycle2", {31'd0, axiov}, 32'd1);
    check_val("good_w0", axiod, 32'hA000_0001);
    check_val("good_pc0", 32'(pc), 32'd0);
    tick();
    check_val("good_w1", axiod, 32'hA000_0002);
    tick();
    check_val("good_w2", axiod, 32'hA000_0003);
    check_val("good_pc2", 32'(pc), 32'd2);
    frame_done = 0;
    idle(3);

    // Killed 5-word frame then good 2-word frame.
    do_reset();
    axior = 1;
    for (int i = 0; i < 5; i++) send_word(32'hB000_0000 + 32'(i));
    frame_kill = 1; tick(); frame_kill = 0;
    idle(3);
    check_val("kill_dropped", {24'd0, frames_dropped}, 32'd1);
    check_val("kill_no_out", {31'd0, axiov}, 32'd0);
    for (int i = 0; i < 2; i++) send_word(32'hC000_0000 + 32'(i));
    frame_done = 1; idle(5); frame_done = 0;

    // Overflow with parser stalled.
    do_reset();
    axior = 0;
    for (int i = 0; i < 6; i++) send_word(32'hD000_0000 + 32'(i));
    frame_done = 1; idle(3); frame_done = 0;
    check_val("ovf_flag", {31'd0, overflow}, 32'd1);
    check_val("ovf_dropped", {24'd0, frames_dropped}, 32'd1);
    check_val("ovf_no_out", {31'd0, axiov}, 32'd0);
    for (int i = 0; i < 2; i++) send_word(32'hE000_0000 + 32'(i));
    frame_done = 1; tick(); frame_done = 0;
    axior = 1; idle(5);

    // Last word coincident with done edge, then kill coincident with done edge.
    do_reset();
    axior = 1;
    send_word(32'h1111_0001);
    axiiv = 1; axiid = 32'h1111_0002; frame_done = 1; tick(); axiiv = 0;
    idle(4); frame_done = 0; tick();
    send_word(32'h2222_0001);
    frame_done = 1; frame_kill = 1; tick(); frame_kill = 0;
    idle(3); frame_done = 0;
    check_val("kill_done_dropped", {24'd0, frames_dropped}, 32'd1);

    // Backpressure 1010 drains, repeated until pc wraps.
    do_reset();
    for (int f = 0; f < 5; f++) begin
      axior = 0;
      for (int i = 0; i < 4; i++) send_word(32'h3000_0000 + 32'(f * 16 + i));
      frame_done = 1; tick(); frame_done = 0;
      for (int c = 0; c < 10; c++) begin
        axior = (c % 2 == 0);
        tick();
      end
      axior = 1; idle(3);
    end
    check_val("pc_wrapped", 32'(pc), 32'(20 % NI));

    // Reset mid-drain.
    axior = 0;
    for (int i = 0; i < 3; i++) send_word(32'h4000_0000 + 32'(i));
    frame_done = 1; tick(); frame_done = 0;
    axior = 1; idle(2);
    do_reset();
    check_val("rst_mid_axiov", {31'd0, axiov}, 32'd0);
    check_val("rst_mid_pc", 32'(pc), 32'd0);
    idle(6);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      axiiv      = 1'($urandom_range(0, 1));
      axiid      = $urandom;
      if ($urandom_range(0, 9) == 0) frame_done = ~frame_done;
      frame_kill = ($urandom_range(0, 29) == 0);
      axior      = ($urandom_range(0, 3) != 0);
      rst        = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 0; axiiv = 0; frame_kill = 0;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_frame_buffer.md
INSTR_FRAME_BUFFER -- requirements
Module: instr_frame_buffer

Interface
REQ-001 The parameter DEPTH SHALL default to 64 and set the number of 32-bit word slots; it is a power of two, at least 4.
REQ-002 clk  input  1  single clock, 50 MHz Ethernet domain.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 axiiv  input  1  incoming word valid, one-cycle pulse per word from the aggregate stage.
REQ-005 axiid  input  32  incoming instruction word.
REQ-006 frame_done  input  1  checksum-complete level from cksum; its rising edge marks a good frame end.
REQ-007 frame_kill  input  1  checksum-failure pulse; the current frame is bad.
REQ-008 axiov  output  1  instruction word valid toward the parser.
REQ-009 axiod  output  32  instruction word.
REQ-010 axior  input  1  parser ready; a transfer occurs when axiov and axior are both high.
REQ-011 pc  output  NUM_INSTRUCTIONS_WIDTH  index of the word currently on axiod.
REQ-012 overflow  output  1  sticky flag, set when a word arrives while the buffer is full.
REQ-013 frames_dropped  output  8  count of discarded frames, saturating at 255.

Function
REQ-014 Storage SHALL be a DEPTH-entry ring with three pointers: wr_ptr (speculative write), cm_ptr (committed end) and rd_ptr (read), each one bit wider than log2(DEPTH) for full/empty detection.
REQ-015 A frame FSM SHALL have three states. IDLE goes to RECV on axiiv. RECV goes to DROP when a word arrives while full. RECV and DROP both return to IDLE on a frame end.
REQ-016 In IDLE or RECV, a word arriving while not full SHALL be written at wr_ptr, and wr_ptr SHALL advance by one.
REQ-017 The buffer is full when wr_ptr minus rd_ptr equals DEPTH. A word arriving when full SHALL be discarded, SHALL set overflow, and SHALL move the FSM to DROP.
REQ-018 In DROP, all further words SHALL be ignored until the frame ends.
REQ-019 A frame end is a rising edge of frame_done, detected with an internal one-cycle delay register, or a frame_kill pulse.
REQ-020 On a rising edge of frame_done in RECV, cm_ptr SHALL be loaded with the post-write wr_ptr, so a word accepted in the same cycle is included in the commit.
REQ-021 On frame_kill, or on a frame_done edge while in DROP, wr_ptr SHALL be rolled back to cm_ptr and frames_dropped SHALL increment; a word arriving in the same cycle is discarded.
REQ-022 If frame_kill and a frame_done edge occur in the same cycle, the kill SHALL take priority.
REQ-023 A frame end while in IDLE SHALL have no effect.
REQ-024 The output SHALL be a single registered stage loaded from the ring at rd_ptr whenever rd_ptr differs from cm_ptr and the stage is empty or being transferred this cycle; sustained throughput is one word per cycle.
REQ-025 Latency SHALL be 2 cycles from a commit edge to axiov high when the buffer was empty.
REQ-026 While axiov is high and axior is low, axiov and axiod SHALL hold stable.
REQ-027 pc SHALL increment by one on each transfer and wrap from NUM_INSTRUCTIONS-1 to 0.
REQ-028 Uncommitted words SHALL never be presented on axiod.

Reset
REQ-029 Reset SHALL clear all pointers, set the FSM to IDLE, and set axiov, axiod, pc, overflow, frames_dropped and the frame_done delay register to 0.
REQ-030 A reset asserted mid-frame or mid-transfer SHALL discard all buffered and committed data; the first word after reset is treated as a new frame.

Structure
REQ-031 NUM_INSTRUCTIONS and NUM_INSTRUCTIONS_WIDTH SHALL come from proctypes; a FrameState enum (IDLE, RECV, DROP) SHALL be added to proctypes.
REQ-032 The ring SHALL be one sub-module, instr_ring_ram: a simple dual-port RAM with synchronous read, inferable as BRAM or LUTRAM.

Verification
REQ-033 Good frame: 3 words (0xA0000001..3) followed by a frame_done edge, with axior held at 1 -> axiov high 2 cycles after the edge, words appear in order with pc 0, 1, 2.
REQ-034 Killed frame: 5 words followed by frame_kill -> nothing is output, frames_dropped = 1, and a following good 2-word frame outputs pc 0, 1.
REQ-035 Overflow with DEPTH=4 and axior=0: 6-word frame plus frame_done -> overflow = 1, frames_dropped = 1, no output; a later committed frame still outputs correctly.
REQ-036 Same-cycle events: last word coincident with the frame_done edge -> that word is committed; kill coincident with the done edge -> frame dropped.
REQ-037 Backpressure: axior toggled 1010 during a 4-word drain -> axiod stable while stalled, no loss or duplication, pc wraps from NUM_INSTRUCTIONS-1 to 0.
REQ-038 Reset asserted mid-drain -> next cycle shows axiov = 0 and pc = 0, and previously committed words never appear.
